// File: rtl/matrix_wr_arbiter_if.sv
// Shared write-port bundle between the three matrix requesters and the storage write side.
interface matrix_wr_arbiter_if;
  logic [2:0]  req;
  logic [5:0]  wr_slot;
  logic [8:0]  wr_row;
  logic [8:0]  wr_col;
  logic [47:0] wr_data;
  logic [2:0]  wr_we;
  logic [8:0]  wr_dim_m;
  logic [8:0]  wr_dim_n;
  logic [2:0]  wr_dim_we;
  logic        err_clr;
  logic [2:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [1:0]  mem_slot;
  logic [2:0]  mem_row;
  logic [2:0]  mem_col;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [2:0]  mem_dim_m;
  logic [2:0]  mem_dim_n;
  logic        mem_dim_we;
  logic        err_timeout;
  logic        err_drop;

  modport master (
    output req, wr_slot, wr_row, wr_col, wr_data, wr_we,
           wr_dim_m, wr_dim_n, wr_dim_we, err_clr,
    input  gnt, owner, busy, mem_slot, mem_row, mem_col, mem_data, mem_we,
           mem_dim_m, mem_dim_n, mem_dim_we, err_timeout, err_drop
  );

  modport slave (
    input  req, wr_slot, wr_row, wr_col, wr_data, wr_we,
           wr_dim_m, wr_dim_n, wr_dim_we, err_clr,
    output gnt, owner, busy, mem_slot, mem_row, mem_col, mem_data, mem_we,
           mem_dim_m, mem_dim_n, mem_dim_we, err_timeout, err_drop
  );
endinterface

// File: rtl/matrix_wr_arbiter.sv
// Round-robin owner arbiter for the matrix write port with an idle watchdog.
//   state   | meaning
//   IDLE    | no owner; pick next eligible requester from rr_ptr
//   GRANT   | owner holds the port; its strobes are forwarded to storage
//   RELEASE | one dead cycle after a release or watchdog revoke
module matrix_wr_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst_n,
  matrix_wr_arbiter_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_n;
  logic [2:0]      gnt_q, gnt_n, mask_q, mask_n;
  logic [1:0]      owner_q, owner_n, rr_q, rr_n;
  logic [WD_W-1:0] wd_q, wd_n;
  logic [1:0]      slot_q, slot_n;
  logic [2:0]      row_q, row_n, col_q, col_n, dm_q, dm_n, dn_q, dn_n;
  logic [15:0]     data_q, data_n;
  logic            we_q, we_n, dwe_q, dwe_n, et_q, et_n, ed_q, ed_n;

  // Lane 3 is a zero lane so owner = 3 never selects a live requester.
  logic [1:0]  slot_a [4];
  logic [2:0]  row_a [4], col_a [4], dm_a [4], dn_a [4];
  logic [15:0] data_a [4];
  logic [3:0]  we4, dwe4, req4;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      slot_a[i] = '0; row_a[i] = '0; col_a[i] = '0;
      data_a[i] = '0; dm_a[i] = '0; dn_a[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      slot_a[i] = bus.wr_slot[2*i +: 2];
      row_a[i]  = bus.wr_row[3*i +: 3];
      col_a[i]  = bus.wr_col[3*i +: 3];
      data_a[i] = bus.wr_data[16*i +: 16];
      dm_a[i]   = bus.wr_dim_m[3*i +: 3];
      dn_a[i]   = bus.wr_dim_n[3*i +: 3];
    end
    we4  = {1'b0, bus.wr_we};
    dwe4 = {1'b0, bus.wr_dim_we};
    req4 = {1'b0, bus.req};
  end

  logic [2:0] elig;
  logic       pick_vld;
  logic [1:0] pick;

  always_comb begin
    logic [2:0] jj;
    elig     = bus.req & ~mask_q;
    pick_vld = 1'b0;
    pick     = 2'd0;
    jj       = 3'd0;
    for (int k = 0; k < 3; k++) begin
      jj = {1'b0, rr_q} + 3'(k);
      if (jj >= 3'd3) jj = jj - 3'd3;
      if (!pick_vld && elig[jj[1:0]]) begin
        pick_vld = 1'b1;
        pick     = jj[1:0];
      end
    end
  end

  logic own_stb, tout, drop;

  always_comb begin
    state_n = state;   gnt_n  = gnt_q;  owner_n = owner_q;
    rr_n    = rr_q;    wd_n   = wd_q;   mask_n  = mask_q & bus.req;
    slot_n  = slot_q;  row_n  = row_q;  col_n   = col_q;  data_n = data_q;
    dm_n    = dm_q;    dn_n   = dn_q;   we_n    = 1'b0;   dwe_n  = 1'b0;
    tout    = 1'b0;    drop   = 1'b0;
    own_stb = we4[owner_q] | dwe4[owner_q];
    case (state)
      IDLE: begin
        drop = |(bus.wr_we | bus.wr_dim_we);
        if (pick_vld) begin
          owner_n = pick;
          gnt_n   = 3'b001 << pick;
          rr_n    = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          wd_n    = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        drop = |((bus.wr_we | bus.wr_dim_we) & ~gnt_q);
        if (!req4[owner_q]) begin
          gnt_n   = 3'b000;
          owner_n = 2'd3;
          state_n = RELEASE;
          if (own_stb) drop = 1'b1;
        end else if (wd_q == WD_LAST && !own_stb) begin
          gnt_n           = 3'b000;
          owner_n         = 2'd3;
          mask_n[owner_q] = 1'b1;
          tout            = 1'b1;
          state_n         = RELEASE;
        end else begin
          we_n  = we4[owner_q];
          dwe_n = dwe4[owner_q];
          if (we4[owner_q]) begin
            slot_n = slot_a[owner_q];
            row_n  = row_a[owner_q];
            col_n  = col_a[owner_q];
            data_n = data_a[owner_q];
          end
          if (dwe4[owner_q]) begin
            dm_n = dm_a[owner_q];
            dn_n = dn_a[owner_q];
          end
          wd_n = own_stb ? '0 : wd_q + 1'b1;
        end
      end
      RELEASE: begin
        drop    = |(bus.wr_we | bus.wr_dim_we);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A set in the same cycle as err_clr wins.
    et_n = tout | (et_q & ~bus.err_clr);
    ed_n = drop | (ed_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;  gnt_q  <= '0;  owner_q <= 2'd3;  rr_q <= '0;
      mask_q <= '0;    wd_q   <= '0;  slot_q  <= '0;    row_q <= '0;
      col_q  <= '0;    data_q <= '0;  dm_q    <= '0;    dn_q  <= '0;
      we_q   <= 1'b0;  dwe_q  <= 1'b0; et_q   <= 1'b0;  ed_q  <= 1'b0;
    end else begin
      state  <= state_n;  gnt_q  <= gnt_n;  owner_q <= owner_n;  rr_q <= rr_n;
      mask_q <= mask_n;   wd_q   <= wd_n;   slot_q  <= slot_n;   row_q <= row_n;
      col_q  <= col_n;    data_q <= data_n; dm_q    <= dm_n;     dn_q  <= dn_n;
      we_q   <= we_n;     dwe_q  <= dwe_n;  et_q    <= et_n;     ed_q  <= ed_n;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state != IDLE);
  assign bus.mem_slot    = slot_q;
  assign bus.mem_row     = row_q;
  assign bus.mem_col     = col_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_dim_m   = dm_q;
  assign bus.mem_dim_n   = dn_q;
  assign bus.mem_dim_we  = dwe_q;
  assign bus.err_timeout = et_q;
  assign bus.err_drop    = ed_q;
endmodule

// File: tb/tb_matrix_wr_arbiter.sv
// Scoreboard bench for matrix_wr_arbiter: directed requester traffic, monitor-side write checking.
module tb_matrix_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_wr_arbiter_if bus ();
  matrix_wr_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic        we, dw;
    logic [1:0]  slot;
    logic [2:0]  row, col;
    logic [15:0] data;
    logic [2:0]  m, n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(int r, bit we, bit dw, logic [1:0] s, logic [2:0] ro, logic [2:0] co,
                       logic [15:0] d, logic [2:0] m, logic [2:0] n, bit push);
    exp_t e;
    bus.wr_slot[2*r +: 2]   = s;
    bus.wr_row[3*r +: 3]    = ro;
    bus.wr_col[3*r +: 3]    = co;
    bus.wr_data[16*r +: 16] = d;
    bus.wr_dim_m[3*r +: 3]  = m;
    bus.wr_dim_n[3*r +: 3]  = n;
    bus.wr_we[r]            = we;
    bus.wr_dim_we[r]        = dw;
    if (push) begin
      e.we = we; e.dw = dw; e.slot = s; e.row = ro; e.col = co;
      e.data = d; e.m = m; e.n = n;
      q.push_back(e);
    end
    cyc(1);
    bus.wr_we[r]     = 1'b0;
    bus.wr_dim_we[r] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.mem_we || bus.mem_dim_we)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got we=%0b dwe=%0b data=%h, expected no write at %0t",
                 bus.mem_we, bus.mem_dim_we, bus.mem_data, $time);
      end else begin
        exp_t e;
        bit bad;
        e = q.pop_front();
        bad = (bus.mem_we !== e.we) || (bus.mem_dim_we !== e.dw);
        if (e.we && ({bus.mem_slot, bus.mem_row, bus.mem_col, bus.mem_data} !==
                     {e.slot, e.row, e.col, e.data})) bad = 1'b1;
        if (e.dw && ({bus.mem_dim_m, bus.mem_dim_n} !== {e.m, e.n})) bad = 1'b1;
        if (bad) begin
          errors++;
          $display("FAIL mem_write: got we=%0b dwe=%0b s=%0d r=%0d c=%0d d=%h m=%0d n=%0d, expected we=%0b dwe=%0b s=%0d r=%0d c=%0d d=%h m=%0d n=%0d",
                   bus.mem_we, bus.mem_dim_we, bus.mem_slot, bus.mem_row, bus.mem_col,
                   bus.mem_data, bus.mem_dim_m, bus.mem_dim_n, e.we, e.dw, e.slot, e.row,
                   e.col, e.data, e.m, e.n);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  int order [4] = '{0, 1, 2, 0};

  initial begin
    bus.req = '0; bus.wr_slot = '0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.wr_we = '0; bus.wr_dim_m = '0; bus.wr_dim_n = '0; bus.wr_dim_we = '0; bus.err_clr = 1'b0;

    // Reset values
    #12;
    chk("rst_gnt", bus.gnt, 3'b000);
    chk("rst_owner", bus.owner, 2'd3);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_we", {bus.mem_we, bus.mem_dim_we}, 2'b00);
    chk("rst_err", {bus.err_timeout, bus.err_drop}, 2'b00);
    rst_n = 1'b1;
    cyc(1);

    // Single requester, 2x3 burst
    bus.req[1] = 1'b1;
    cyc(1);
    chk("single_gnt", bus.gnt, 3'b010);
    chk("single_owner", bus.owner, 2'd1);
    chk("single_busy", bus.busy, 1'b1);
    drive(1, 0, 1, 2'd0, 3'd0, 3'd0, 16'h0000, 3'd2, 3'd3, 1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        drive(1, 1, 0, 2'd1, 3'(r), 3'(c), 16'hA000 + 16'(r * 3 + c), 3'd0, 3'd0, 1);
    bus.req[1] = 1'b0;
    cyc(1);
    chk("single_rel_gnt", bus.gnt, 3'b000);
    chk("single_rel_owner", bus.owner, 2'd3);
    chk("single_rel_busy", bus.busy, 1'b1);
    cyc(1);
    chk("single_idle_busy", bus.busy, 1'b0);
    chk("single_err_drop", bus.err_drop, 1'b0);

    // Reset mid-burst
    bus.req[1] = 1'b1;
    cyc(1);
    chk("rmid_gnt", bus.gnt, 3'b010);
    drive(1, 1, 0, 2'd2, 3'd1, 3'd1, 16'hB001, 3'd0, 3'd0, 1);
    drive(1, 1, 0, 2'd3, 3'd2, 3'd2, 16'hB002, 3'd0, 3'd0, 1);
    bus.wr_we[1] = 1'b1;
    bus.wr_data[31:16] = 16'hDEAD;
    #5 rst_n = 1'b0;
    #1;
    chk("rmid_gnt0", bus.gnt, 3'b000);
    chk("rmid_owner", bus.owner, 2'd3);
    chk("rmid_busy", bus.busy, 1'b0);
    chk("rmid_mem", {bus.mem_we, bus.mem_dim_we, bus.mem_slot, bus.mem_data}, 20'h0);
    chk("rmid_err", {bus.err_timeout, bus.err_drop}, 2'b00);
    bus.wr_we = '0;
    bus.req = '0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("rmid_after", {bus.mem_we, bus.gnt}, 4'h0);

    // Round-robin with all three requesting
    bus.req = 3'b111;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      int r;
      r = order[i];
      chk("rr_gnt", bus.gnt, 3'b001 << r);
      chk("rr_owner", bus.owner, r);
      drive(r, 1, 0, 2'(r), 3'(i), 3'd0, 16'h1000 + 16'(i * 16), 3'd0, 3'd0, 1);
      drive(r, 1, 0, 2'(r), 3'(i), 3'd1, 16'h1001 + 16'(i * 16), 3'd0, 3'd0, 1);
      bus.req[r] = 1'b0;
      cyc(1);
      chk("rr_release", {bus.gnt, bus.busy}, 4'b0001);
      bus.req[r] = 1'b1;
      cyc(1);
      chk("rr_idle", bus.gnt, 3'b000);
      cyc(1);
    end
    bus.req = 3'b000;
    cyc(3);

    // Drops and error clear, owner = 0
    bus.req[0] = 1'b1;
    cyc(1);
    chk("drop_gnt", bus.gnt, 3'b001);
    drive(2, 1, 0, 2'd3, 3'd7, 3'd7, 16'hBAD2, 3'd0, 3'd0, 0);
    chk("drop_err", bus.err_drop, 1'b1);
    chk("drop_mem_we", bus.mem_we, 1'b0);
    bus.err_clr = 1'b1; cyc(1); bus.err_clr = 1'b0;
    chk("drop_clr", bus.err_drop, 1'b0);
    bus.err_clr = 1'b1;
    drive(2, 1, 0, 2'd3, 3'd7, 3'd7, 16'hBAD3, 3'd0, 3'd0, 0);
    bus.err_clr = 1'b0;
    chk("drop_set_wins", bus.err_drop, 1'b1);
    bus.err_clr = 1'b1; cyc(1); bus.err_clr = 1'b0;
    chk("drop_clr2", bus.err_drop, 1'b0);
    drive(0, 1, 1, 2'd1, 3'd4, 3'd5, 16'hC0DE, 3'd6, 3'd7, 1);
    chk("both_strobes", {bus.mem_we, bus.mem_dim_we}, 2'b11);
    bus.req[0] = 1'b0;
    drive(0, 1, 0, 2'd2, 3'd1, 3'd1, 16'hBAD4, 3'd0, 3'd0, 0);
    chk("fall_strobe_drop", bus.err_drop, 1'b1);
    chk("fall_strobe_gnt", bus.gnt, 3'b000);
    bus.err_clr = 1'b1; cyc(1); bus.err_clr = 1'b0;
    cyc(2);

    // Watchdog timeout, TIMEOUT = 8
    bus.req[2] = 1'b1;
    cyc(1);
    chk("wd_gnt", bus.gnt, 3'b100);
    cyc(7);
    chk("wd_before", bus.gnt, 3'b100);
    cyc(1);
    chk("wd_revoke", bus.gnt, 3'b000);
    chk("wd_owner", bus.owner, 2'd3);
    chk("wd_err", bus.err_timeout, 1'b1);
    cyc(4);
    chk("wd_masked", bus.gnt, 3'b000);
    bus.req[2] = 1'b0;
    cyc(1);
    bus.req[2] = 1'b1;
    cyc(1);
    chk("wd_regrant", bus.gnt, 3'b100);
    bus.req[2] = 1'b0;
    bus.err_clr = 1'b1; cyc(1); bus.err_clr = 1'b0;
    chk("wd_clr", bus.err_timeout, 1'b0);
    cyc(3);

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_wr_arbiter.md
# matrix_wr_arbiter

Write-port arbiter for the matrix storage. It shares the single slot/row/col/data/dimension write port between three requesters: 0 = manual input, 1 = random generator, 2 = ALU result writer. Each requester owns the port for a whole transaction, and grants rotate round-robin. A watchdog revokes the port from a granted requester that stops writing.

## Interface
- TIMEOUT, default 1024: idle cycles allowed to a granted owner before its grant is revoked (minimum 2).
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  3  request per requester; held high for the whole transaction.
- wr_slot  in  6  per-requester slot index; requester i uses [2i+:2].
- wr_row / wr_col  in  9 each  per-requester row and column; requester i uses [3i+:3].
- wr_data  in  48  per-requester element data; requester i uses [16i+:16].
- wr_we  in  3  per-requester element write strobe.
- wr_dim_m / wr_dim_n  in  9 each  per-requester dimensions; requester i uses [3i+:3].
- wr_dim_we  in  3  per-requester dimension write strobe.
- err_clr  in  1  clears both sticky error flags.
- gnt  out  3  one-hot grant, or all zero.
- owner  out  2  index of the granted requester; 3 = none.
- busy  out  1  state is not IDLE.
- mem_slot / mem_row / mem_col / mem_data  out  2/3/3/16  registered element write to storage.
- mem_we  out  1  registered element write strobe.
- mem_dim_m / mem_dim_n  out  3/3  registered dimension write.
- mem_dim_we  out  1  registered dimension write strobe.
- err_timeout  out  1  sticky; set when the watchdog revokes a grant.
- err_drop  out  1  sticky; set when a non-owner strobe is discarded.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE: if any eligible req is high, pick the first one at or after rr_ptr, cyclically 0→1→2→0.
  - Load owner, set gnt[owner], set rr_ptr = owner+1 mod 3, clear the watchdog, go to GRANT.
  - Eligible means req high and the requester's mask bit clear.
- GRANT, ordered checks:
  1. req[owner] low: drop gnt, owner = 3, go to RELEASE.
  2. Otherwise, watchdog = TIMEOUT-1 with no owner strobe this cycle: drop gnt, set the owner's mask bit, set err_timeout, go to RELEASE.
  3. Otherwise, forward the owner's write bus to the mem_* registers.
  - The watchdog clears on any owner we or dim_we and otherwise increments.
- RELEASE: one dead cycle, mem strobes are 0, then go to IDLE.
- A requester's mask bit clears when its req is low. A timed-out requester is therefore re-eligible only after it drops req.
- Write forwarding:
  - mem_we = wr_we[owner] and mem_dim_we = wr_dim_we[owner], registered.
  - Address, data and dimension registers load only when the matching strobe is high and hold otherwise.
  - Element and dimension strobes in the same cycle are both forwarded.
- Drops: any wr_we/wr_dim_we bit from a requester that is not the owner, or any strobe in IDLE or RELEASE, is discarded and sets err_drop.
- A strobe from the owner in the cycle its req falls is also discarded and sets err_drop.
- Error flags: err_clr clears both flags. If a set condition occurs in the same cycle as err_clr, the set wins.
- Reset values:
  - state IDLE, gnt 0, owner 3, busy 0, rr_ptr 0, mask 0, watchdog 0.
  - All mem_* outputs 0; err_timeout 0, err_drop 0.
  - Reset asserted mid-transaction aborts immediately with no further mem strobes.

## Timing
- Grant latency: req rises while IDLE at edge t, so gnt is high after edge t+1.
- Write latency: owner strobe sampled at edge k appears on mem_* in the cycle after edge k, with 1-cycle latency and full throughput (one write per cycle).
- Release: req falls before edge r, so gnt is low after r, RELEASE holds for cycle r+1, and the earliest next grant is after edge r+2.
- Timeout: the grant is revoked at the edge on which the watchdog reaches TIMEOUT-1, i.e. TIMEOUT cycles after the last owner strobe or after the grant.
- Requesters must not drive strobes before seeing gnt high.

## Test plan
- Single requester: req[1] rises at cycle 0, gnt = 3'b010 at cycle 1. A 2×3 burst (dim write, then 6 element writes) reproduces mem_* one cycle late; err_drop stays 0.
- Round-robin: req = 3'b111 held, each requester releases after 2 writes. Grant order 0, 1, 2, 0 with exactly one RELEASE cycle between grants.
- Drop: while requester 0 owns the port, pulse wr_we[2]. mem_we is not driven by requester 2 and err_drop = 1; err_clr returns it to 0.
- Timeout with TIMEOUT = 8: requester 2 is granted and writes nothing. gnt drops 8 cycles after the grant and err_timeout = 1. Requester 2 with req still high is not regranted; after req drops and rises again it is granted.
- Simultaneous: err_clr in the same cycle as a new drop leaves err_drop = 1. Dim and element strobes in one cycle produce both mem strobes in the same cycle.
- Reset mid-burst: assert rst_n low during requester 1's writes. All outputs return to reset values asynchronously and owner = 3.
